// File: rtl/seg7_scan_driver.sv
// Eight-digit time-multiplexed scan driver: digit/dp storage with single and bulk
// write ports, a refresh prescaler and a 3-bit select index feeding a 7-seg decoder.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic        wr_dp,
    input  logic        load_all,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_dp,
    input  logic        scan_en,
    output logic [3:0]  c,
    output logic [2:0]  s,
    output logic        dpoint,
    output logic        digit_tick
);

    logic [3:0]       w_digit [8];
    logic             w_dp    [8];

    logic [CNT_W-1:0] r_pre_cnt;
    logic [2:0]       r_s;
    logic             r_tick;

    logic [CNT_W-1:0] w_pre_next;
    logic [2:0]       w_s_next;
    logic             w_tick_next;
    logic             w_terminal;

    // Each slot owns its registers; load_all outranks the single-digit port.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slot
            logic [3:0] r_digit;
            logic       r_dp;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_digit <= 4'h0;
                    r_dp    <= 1'b0;
                end else if (load_all) begin
                    r_digit <= load_data[4*gi +: 4];
                    r_dp    <= load_dp[gi];
                end else if (wr_en && (wr_addr == 3'(gi))) begin
                    r_digit <= wr_data;
                    r_dp    <= wr_dp;
                end
            end

            assign w_digit[gi] = r_digit;
            assign w_dp[gi]    = r_dp;
        end
    endgenerate

    assign w_terminal = (r_pre_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
            r_s       <= 3'd0;
            r_tick    <= 1'b0;
        end else begin
            r_pre_cnt <= w_pre_next;
            r_s       <= w_s_next;
            r_tick    <= w_tick_next;
        end
    end

    // Tick is registered alongside the index so it marks the first cycle of the new s.
    always_comb begin
        w_pre_next  = r_pre_cnt;
        w_s_next    = r_s;
        w_tick_next = 1'b0;
        if (scan_en) begin
            if (w_terminal) begin
                w_pre_next  = '0;
                w_s_next    = r_s + 3'd1;
                w_tick_next = 1'b1;
            end else begin
                w_pre_next  = r_pre_cnt + CNT_W'(1);
            end
        end
    end

    assign c          = w_digit[r_s];
    assign dpoint     = w_dp[r_s];
    assign s          = r_s;
    assign digit_tick = r_tick;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed scan driver that produces the digit-value, digit-select and decimal-point signals consumed by the team's combinational 7-segment decoder/anode-select block. It holds eight 4-bit digit registers plus eight decimal-point bits, loaded by a single-digit write port or a 32-bit bulk load. It rotates the select index 0→7 at a programmable refresh rate, presenting the matching nibble and decimal point for each slot.

## Interface
- REFRESH_DIV, default 100000: clock cycles each digit is held; legal range ≥ 2.
- CNT_W, default 17: prescaler width; must satisfy 2^CNT_W ≥ REFRESH_DIV.

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  single-digit write strobe.
- wr_addr  input  3  digit index for single-digit write.
- wr_data  input  4  nibble for single-digit write.
- wr_dp  input  1  decimal-point bit for single-digit write.
- load_all  input  1  bulk-load strobe.
- load_data  input  32  bulk nibbles; digit k = load_data[4k+3:4k].
- load_dp  input  8  bulk decimal points; digit k = load_dp[k].
- scan_en  input  1  1 = scanning advances; 0 = prescaler and index frozen.
- c  output  4  nibble of currently selected digit (to decoder c).
- s  output  3  currently selected digit index (to decoder s).
- dpoint  output  1  decimal point of currently selected digit.
- digit_tick  output  1  one-cycle pulse in the cycle s advances.

## Operation
- Storage: digit[0..7] (4 b each), dp[0..7] (1 b each).
- Write priority per cycle: rst > load_all > wr_en. load_all replaces all 8 digits and dp bits; wr_en replaces only digit[wr_addr] and dp[wr_addr]. Simultaneous load_all and wr_en: wr_en ignored.
- Prescaler pre_cnt counts 0..REFRESH_DIV-1 while scan_en=1; at terminal count (REFRESH_DIV-1) it wraps to 0 and s increments.
- s wraps 7→0 (mod-8, no extra cycle).
- scan_en=0: pre_cnt and s hold; digit_tick=0; writes still accepted.
- c = digit[s], dpoint = dp[s], read combinationally from registered state; no blanking, no arbitration with writes.
- No FSM beyond prescaler + 3-bit index; index states S0..S7 advance only on terminal count.

## Timing
- Reset values: all digit=4'h0, all dp=0, s=3'd0, pre_cnt=0, digit_tick=0; hence c=4'h0, dpoint=0 during and immediately after reset.
- rst asserted mid-scan: next edge returns all state to reset values regardless of wr_en/load_all/scan_en.
- Write latency: data written at edge N visible on c/dpoint from after edge N (same cycle as new register value) if the written index equals s.
- Index advance: with scan_en continuously 1 from reset release, s changes after every REFRESH_DIV-th rising edge; first change after edge REFRESH_DIV following reset deassertion.
- digit_tick registered: high for exactly the one cycle in which the new s value is first present.
- Full rotation period = 8 × REFRESH_DIV cycles.
- scan_en toggled low at terminal count: no advance; count resumes from held value when re-enabled.

## Test plan
- Reset: hold rst 3 cycles with random write strobes active -> c=0, s=0, dpoint=0, digit_tick=0; all digits read back 0 over one rotation.
- Bulk load + rotation (REFRESH_DIV=4): load_all with load_data=32'h76543210, load_dp=8'b1010_0101 -> s steps 0..7 every 4 cycles, c equals s, dpoint=1 at s=0,2,5,7; s wraps 7→0 after 32 cycles; digit_tick pulses exactly 8 times per rotation.
- Single write to live digit: while s=3, wr_en with wr_addr=3, wr_data=4'hA, wr_dp=1 -> c=4'hA, dpoint=1 in the cycle after the edge; other digits unchanged.
- Write collision: same cycle load_all (load_data=32'hFFFFFFFF, load_dp=8'h00) and wr_en (addr 2, data 4'h5) -> digit[2]=4'hF, dp[2]=0.
- Scan freeze: deassert scan_en at s=5 for 20 cycles -> s stays 5, no digit_tick; re-assert -> advance resumes with remaining prescaler count.
- Reset mid-scan: assert rst while s=6 after bulk load -> next cycle s=0, c=0, dpoint=0; scanning restarts with first advance REFRESH_DIV cycles after release.
